// File: rtl/sram_arbiter.sv
// Two-port arbiter for one 32-bit asynchronous SRAM bank: data port has fixed priority over fetch.
// Owns pin sequencing (address setup, OE/WE strobes, bus tristate) and read capture.
module sram_arbiter #(
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [19:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [19:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic [19:0] sram_addr_o,
  inout  wire  [31:0] sram_data_io,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic [3:0]  sram_be_n_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, RD, RD_ACK, WR_SETUP, WR_PULSE, WR_ACK} state_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  state_t      state_q, state_d;
  logic        gnt_d_q, gnt_d_d;
  logic [3:0]  be_q, be_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        drive;

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_d_q    <= 1'b0;
      be_q       <= 4'h0;
      addr_q     <= 20'h0;
      wdata_q    <= 32'h0;
      cnt_q      <= 4'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      gnt_d_q    <= gnt_d_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Pins depend only on registered state and latched fields, never on live requests.
  always_comb begin
    state_d     = state_q;
    gnt_d_d     = gnt_d_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    sram_ce_n_o = 1'b1;
    sram_oe_n_o = 1'b1;
    sram_we_n_o = 1'b1;
    sram_be_n_o = 4'hF;
    drive       = 1'b0;
    if_ack_o    = 1'b0;
    d_ack_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req_i) begin
          gnt_d_d = 1'b1;
          be_d    = d_be_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          cnt_d   = d_we_i ? WR_LOAD : RD_LOAD;
          state_d = d_we_i ? WR_SETUP : RD;
        end else if (if_req_i) begin
          // Fetches read the whole word, so all byte lanes are enabled.
          gnt_d_d = 1'b0;
          be_d    = 4'hF;
          addr_d  = if_addr_i;
          cnt_d   = RD_LOAD;
          state_d = RD;
        end
      end
      RD: begin
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_be_n_o = ~be_q;
        if (cnt_q == 4'h0) begin
          if (gnt_d_q) d_rdata_d = sram_data_io;
          else         if_rdata_d = sram_data_io;
          state_d = RD_ACK;
        end else begin
          cnt_d = cnt_q - 4'h1;
        end
      end
      RD_ACK: begin
        if_ack_o = ~gnt_d_q;
        d_ack_o  = gnt_d_q;
        state_d  = IDLE;
      end
      WR_SETUP: begin
        sram_ce_n_o = 1'b0;
        sram_be_n_o = ~be_q;
        drive       = 1'b1;
        state_d     = WR_PULSE;
      end
      WR_PULSE: begin
        sram_ce_n_o = 1'b0;
        sram_we_n_o = 1'b0;
        sram_be_n_o = ~be_q;
        drive       = 1'b1;
        if (cnt_q == 4'h0) state_d = WR_ACK;
        else               cnt_d   = cnt_q - 4'h1;
      end
      WR_ACK: begin
        sram_ce_n_o = 1'b0;
        sram_be_n_o = ~be_q;
        drive       = 1'b1;
        d_ack_o     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram_data_io = drive ? wdata_q : 32'hz;
  assign sram_addr_o  = addr_q;
  assign if_rdata_o   = if_rdata_q;
  assign d_rdata_o    = d_rdata_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: hand sequences, a vector table and randomized traffic against a
// transaction-level memory/latency model. A second instance covers the longer wait settings.
module tb_sram_arbiter;
  localparam int RDW = 1, WRW = 1;

  logic clk50 = 1'b0;
  logic rst = 1'b1;
  always #10 clk50 = ~clk50;

  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [19:0] if_addr = 0, d_addr = 0;
  logic [3:0]  d_be = 0;
  logic [31:0] d_wdata = 0;
  logic        if_ack, d_ack, ce_n, oe_n, we_n, busy;
  logic [31:0] if_rdata, d_rdata;
  logic [19:0] sram_addr;
  logic [3:0]  be_n;
  wire  [31:0] sram_data;

  sram_arbiter #(.RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .clk50(clk50), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack), .d_rdata_o(d_rdata),
    .sram_addr_o(sram_addr), .sram_data_io(sram_data), .sram_ce_n_o(ce_n),
    .sram_oe_n_o(oe_n), .sram_we_n_o(we_n), .sram_be_n_o(be_n), .busy_o(busy));

  // Second instance with longer strobes; its "SRAM" returns an address-derived pattern.
  logic        if_req_b = 0, d_req_b = 0, d_we_b = 0;
  logic [19:0] if_addr_b = 0, d_addr_b = 0;
  logic [3:0]  d_be_b = 0;
  logic [31:0] d_wdata_b = 0;
  logic        if_ack_b, d_ack_b, ce_n_b, oe_n_b, we_n_b, busy_b;
  logic [31:0] if_rdata_b, d_rdata_b;
  logic [19:0] sram_addr_b;
  logic [3:0]  be_n_b;
  wire  [31:0] sram_data_b;

  sram_arbiter #(.RD_WAIT(3), .WR_WAIT(2)) dut_b (
    .clk50(clk50), .rst(rst),
    .if_req_i(if_req_b), .if_addr_i(if_addr_b), .if_ack_o(if_ack_b), .if_rdata_o(if_rdata_b),
    .d_req_i(d_req_b), .d_we_i(d_we_b), .d_be_i(d_be_b), .d_addr_i(d_addr_b), .d_wdata_i(d_wdata_b),
    .d_ack_o(d_ack_b), .d_rdata_o(d_rdata_b),
    .sram_addr_o(sram_addr_b), .sram_data_io(sram_data_b), .sram_ce_n_o(ce_n_b),
    .sram_oe_n_o(oe_n_b), .sram_we_n_o(we_n_b), .sram_be_n_o(be_n_b), .busy_o(busy_b));

  assign sram_data_b = (!ce_n_b && !oe_n_b) ? (32'hA5A5_0000 | {12'h0, sram_addr_b}) : 32'hz;

  // Asynchronous SRAM model: drives on OE, latches enabled bytes on the rising edge of WE_n.
  logic [31:0] mem [256];
  logic        pl_stb = 0;
  logic [7:0]  pl_addr = 0;
  logic [31:0] pl_data = 0;
  assign sram_data = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 32'hz;
  always @(posedge we_n or posedge pl_stb) begin
    if (pl_stb) mem[pl_addr] <= pl_data;
    else if (!ce_n)
      for (int b = 0; b < 4; b++)
        if (!be_n[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_data[b*8 +: 8];
  end

  logic [31:0] ref_mem [256];
  int checks = 0, errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    pl_addr = 8'(a); pl_data = v; pl_stb = 1; #1; pl_stb = 0; #1;
    ref_mem[a] = v;
  endtask

  function automatic void ref_write(input int a, input logic [3:0] be, input logic [31:0] v);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][b*8 +: 8] = v[b*8 +: 8];
  endfunction

  // One transaction set issued at cycle 0; returns the cycle of each port's ack (-1 if none).
  task automatic run(input bit d_on, input bit we, input logic [3:0] be, input logic [19:0] da,
                     input logic [31:0] wd, input bit f_on, input logic [19:0] fa,
                     output int dl, output int fl);
    dl = -1; fl = -1;
    d_req = d_on; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
    if_req = f_on; if_addr = fa;
    for (int c = 1; c <= 60 && ((d_on && dl < 0) || (f_on && fl < 0)); c++) begin
      tick();
      if (d_ack) begin dl = c; d_req = 0; end
      if (if_ack) begin fl = c; if_req = 0; end
    end
    d_req = 0; if_req = 0;
    tick();
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [3:0]  be;
    logic [19:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rd;
    logic [31:0] exp_drd;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int dl, fl, edl, efl;
    bit noack;
    tbl[0] = '{1, 1, 4'hF,    20'h5, 32'h11223344, 3, 32'h0,        32'hAABB5678};
    tbl[1] = '{1, 0, 4'hF,    20'h5, 32'h0,        2, 32'h11223344, 32'h11223344};
    tbl[2] = '{1, 1, 4'b0100, 20'h5, 32'h00AA0000, 3, 32'h0,        32'h11223344};
    tbl[3] = '{0, 0, 4'hF,    20'h5, 32'h0,        2, 32'h11AA3344, 32'h11223344};
    tbl[4] = '{1, 1, 4'b0000, 20'h5, 32'hFFFFFFFF, 3, 32'h0,        32'h11223344};
    tbl[5] = '{1, 0, 4'hF,    20'h5, 32'h0,        2, 32'h11AA3344, 32'h11AA3344};
    tbl[6] = '{1, 1, 4'b1000, 20'h5, 32'h99000000, 3, 32'h0,        32'h11AA3344};
    tbl[7] = '{0, 0, 4'hF,    20'h5, 32'h0,        2, 32'h99AA3344, 32'h11AA3344};

    for (int i = 0; i < 256; i++) preload(i, (32'(i) * 32'h01010101) ^ 32'h5A5A_0000);
    preload(16'h10, 32'hDEADBEEF);
    preload(16'h20, 32'hAABBCCDD);

    repeat (2) tick();
    rst = 0;
    repeat (5) tick();
    check("rst_ce_n", 32'(ce_n), 1);
    check("rst_oe_n", 32'(oe_n), 1);
    check("rst_we_n", 32'(we_n), 1);
    check("rst_be_n", 32'(be_n), 32'hF);
    check("rst_addr", 32'(sram_addr), 0);
    check("rst_acks", {30'h0, if_ack, d_ack}, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rdata", if_rdata | d_rdata, 0);

    // Fetch read of 0x10
    if_req = 1; if_addr = 20'h10;
    tick();
    check("frd_c1_addr", 32'(sram_addr), 32'h10);
    check("frd_c1_ce_oe", {30'h0, ce_n, oe_n}, 0);
    check("frd_c1_be_n", 32'(be_n), 0);
    check("frd_c1_ack", 32'(if_ack), 0);
    tick();
    check("frd_c2_ack", 32'(if_ack), 1);
    check("frd_c2_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 0;
    tick();
    check("frd_c3_busy", 32'(busy), 0);
    check("frd_c3_ack", 32'(if_ack), 0);

    // Partial data write to 0x20
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 20'h20; d_wdata = 32'h12345678;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("wr_c%0d_we_n", c), 32'(we_n), (c == 2) ? 0 : 1);
      check($sformatf("wr_c%0d_ack", c), 32'(d_ack), (c == 3) ? 1 : 0);
      if (c <= 3) begin
        check($sformatf("wr_c%0d_bus", c), sram_data, 32'h12345678);
        check($sformatf("wr_c%0d_be_n", c), 32'(be_n), 32'hC);
      end
      if (c == 3) d_req = 0;
    end
    ref_write(16'h20, 4'b0011, 32'h12345678);
    check("wr_mem", mem[8'h20], 32'hAABB5678);

    // Simultaneous requests: data first, fetch after an IDLE cycle
    d_req = 1; d_we = 0; d_addr = 20'h20; if_req = 1; if_addr = 20'h10;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("sim_c%0d_dack", c), 32'(d_ack), (c == 2) ? 1 : 0);
      check($sformatf("sim_c%0d_iack", c), 32'(if_ack), (c == 5) ? 1 : 0);
      check($sformatf("sim_c%0d_busy", c), 32'(busy), (c == 3) ? 0 : 1);
      if (c == 2) d_req = 0;
      if (c == 5) if_req = 0;
    end
    tick();
    check("sim_drdata", d_rdata, 32'hAABB5678);
    check("sim_irdata", if_rdata, 32'hDEADBEEF);

    // Vector table
    foreach (tbl[i]) begin
      run(tbl[i].is_d, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata,
          !tbl[i].is_d, tbl[i].addr, dl, fl);
      if (tbl[i].is_d && tbl[i].we) ref_write(int'(tbl[i].addr), tbl[i].be, tbl[i].wdata);
      check($sformatf("tbl%0d_lat", i), tbl[i].is_d ? dl : fl, tbl[i].lat);
      check($sformatf("tbl%0d_other_ack", i), tbl[i].is_d ? fl : dl, -1);
      if (!tbl[i].we) check($sformatf("tbl%0d_rdata", i), tbl[i].is_d ? d_rdata : if_rdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d_drdata", i), d_rdata, tbl[i].exp_drd);
    end

    // Longer wait settings on the second instance
    if_req_b = 1; if_addr_b = 20'h00123;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("b_rd_c%0d_oe_n", c), 32'(oe_n_b), (c <= 3) ? 0 : 1);
      check($sformatf("b_rd_c%0d_ack", c), 32'(if_ack_b), (c == 4) ? 1 : 0);
    end
    if_req_b = 0;
    check("b_rd_rdata", if_rdata_b, 32'hA5A50123);
    tick();
    d_req_b = 1; d_we_b = 1; d_be_b = 4'hF; d_addr_b = 20'h00044; d_wdata_b = 32'h0BADCAFE;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("b_wr_c%0d_we_n", c), 32'(we_n_b), (c == 2 || c == 3) ? 0 : 1);
      check($sformatf("b_wr_c%0d_ack", c), 32'(d_ack_b), (c == 4) ? 1 : 0);
      check($sformatf("b_wr_c%0d_bus", c), sram_data_b, 32'h0BADCAFE);
    end
    d_req_b = 0;
    tick();
    check("b_idle_busy", 32'(busy_b), 0);

    // Reset in the middle of a write pulse
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 20'h30; d_wdata = 32'hCAFEF00D;
    tick();
    tick();
    check("rmw_pulse_we_n", 32'(we_n), 0);
    #3 rst = 1;
    #1;
    check("rmw_we_n", 32'(we_n), 1);
    check("rmw_ce_n", 32'(ce_n), 1);
    check("rmw_be_n", 32'(be_n), 32'hF);
    check("rmw_busy", 32'(busy), 0);
    check("rmw_ack", 32'(d_ack), 0);
    d_req = 0;
    tick();
    rst = 0;
    noack = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (d_ack || if_ack) noack = 0;
    end
    check("rmw_no_ack", 32'(noack), 1);
    run(1, 0, 4'hF, 20'h10, 0, 0, 0, dl, fl);
    check("rmw_after_lat", dl, RDW + 1);
    check("rmw_after_rdata", d_rdata, 32'hDEADBEEF);

    // Randomized traffic against the transaction-level model
    for (int n = 0; n < 150; n++) begin
      int mode;
      bit d_on, f_on, we;
      logic [3:0] be;
      logic [31:0] wd, exp_d, exp_f;
      int da, fa;
      mode = $urandom_range(0, 2);
      d_on = (mode != 1); f_on = (mode != 0);
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      wd = $urandom;
      da = $urandom_range(64, 255);
      fa = $urandom_range(64, 255);
      edl = d_on ? (we ? WRW + 2 : RDW + 1) : -1;
      efl = f_on ? (d_on ? edl + 1 + RDW + 1 : RDW + 1) : -1;
      exp_d = ref_mem[da];
      if (d_on && we) ref_write(da, be, wd);
      exp_f = ref_mem[fa];
      run(d_on, we, be, 20'(da), wd, f_on, 20'(fa), dl, fl);
      check($sformatf("rnd%0d_dlat", n), dl, edl);
      check($sformatf("rnd%0d_flat", n), fl, efl);
      if (d_on && !we) check($sformatf("rnd%0d_drdata", n), d_rdata, exp_d);
      if (d_on && we) check($sformatf("rnd%0d_mem", n), mem[da], ref_mem[da]);
      if (f_on) check($sformatf("rnd%0d_irdata", n), if_rdata, exp_f);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
